// File: rtl/lcd_spi_feeder.sv
//------------------------------------------------------------------------------
// Module   : lcd_spi_feeder
// Purpose  : FIFO-buffered byte feeder for the LCD SPI transmitter; sequences
//            D/C, data setup, active-low cs and a minimum inter-byte cs gap.
//            Optional macro DELAY_CMD_EN adds timed delay entries.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_spi_feeder #(
    parameter int DEPTH   = 16,
    parameter int CS_GAP  = 4,
    parameter int SETUP   = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     wr_dc,
`ifdef DELAY_CMD_EN
    input  logic                     wr_delay,
`endif
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               tx_data,
    output logic                     tx_cs,
    input  logic                     tx_valid,
    output logic                     lcd_dc,
    output logic                     busy,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef DELAY_CMD_EN
    localparam int EW      = 10;
    localparam int DLY_MAX = 255 * 1024;
`else
    localparam int EW      = 9;
    localparam int DLY_MAX = 0;
`endif
    localparam int T1      = (TIMEOUT > SETUP) ? TIMEOUT : SETUP;
    localparam int T2      = (T1 > CS_GAP) ? T1 : CS_GAP;
    localparam int CNT_TOP = (T2 > DLY_MAX) ? T2 : DLY_MAX;
    localparam int CW      = $clog2(CNT_TOP + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_XFER  = 3'd3,
        ST_GAP   = 3'd4,
        ST_WAIT  = 3'd5
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [EW-1:0]   head_q;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            overflow_q;
    logic            timeout_err_q;
    logic [7:0]      tx_data_q;
    logic            tx_cs_q;
    logic            lcd_dc_q;
    logic [EW-1:0]   w_entry;
    logic            w_pop;
    logic            w_push_ok;

`ifdef DELAY_CMD_EN
    logic [17:0]     w_dly_last;
    assign w_entry    = {wr_delay, wr_dc, wr_data};
    assign w_dly_last = {head_q[7:0], 10'd0} - 18'd1;
`else
    assign w_entry = {wr_dc, wr_data};
`endif

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    // A pop only ever happens from IDLE, so a full FIFO accepts a push that same cycle.
    assign w_pop     = (state_q == ST_IDLE) && !empty;
    assign w_push_ok = wr_en && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                level_q <= level_q + LW'(1);
            end else if (!w_push_ok && w_pop) begin
                level_q <= level_q - LW'(1);
            end
            if (wr_en && !w_push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            head_q        <= '0;
            tx_data_q     <= 8'd0;
            tx_cs_q       <= 1'b1;
            lcd_dc_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_pop) begin
                        head_q  <= mem_q[rd_ptr_q];
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q <= '0;
`ifdef DELAY_CMD_EN
                    if (head_q[9]) begin
                        state_q <= (head_q[7:0] == 8'd0) ? ST_IDLE : ST_WAIT;
                    end else
`endif
                    begin
                        tx_data_q <= head_q[7:0];
                        lcd_dc_q  <= head_q[8];
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == CW'(SETUP - 1)) begin
                        tx_cs_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_XFER;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_XFER: begin
                    if (tx_valid) begin
                        tx_cs_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        tx_cs_q       <= 1'b1;
                        timeout_err_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CW'(CS_GAP - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`ifdef DELAY_CMD_EN
                ST_WAIT: begin
                    if (cnt_q == CW'(w_dly_last)) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif
                default: begin
                    tx_cs_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign level       = level_q;
    assign tx_data     = tx_data_q;
    assign tx_cs       = tx_cs_q;
    assign lcd_dc      = lcd_dc_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE) || !empty;

endmodule

`default_nettype wire
